// File: rtl/sram_arb_pkg.sv
// Shared constants, request record and winner-pick helper for the SRAM port arbiter.
// The pick helper serves both the fixed-priority and round-robin builds.
package sram_arb_pkg;

    localparam int SramAddrW = 10;
    localparam int SramDataW = 32;
    localparam int MaxReq    = 4;

    typedef struct packed {
        logic                     we;
        logic [SramAddrW-1:0]     addr;
        logic [SramDataW-1:0]     wdata;
        logic [SramDataW/8-1:0]   wmask;
    } sram_req_t;

    // Search starts one past 'last' and wraps modulo n; last = n-1 gives lowest-index priority.
    function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] elig,
                                                  input logic [1:0]        last,
                                                  input logic [2:0]        n);
        logic [MaxReq-1:0] gnt;
        logic              found;
        logic [1:0]        idx;
        gnt   = {MaxReq{1'b0}};
        found = 1'b0;
        for (int i = 1; i <= MaxReq; i++) begin
            idx = 2'((int'(last) + i) % int'(n));
            if (!found && (i <= int'(n)) && elig[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Generic winner picker; holds the round-robin pointer when SRAM_ARB_ROUND_ROBIN_EN is
// defined, otherwise it is a stateless lowest-index-first priority picker.
module sram_arb_rr
    import sram_arb_pkg::*;
#(
    parameter int NumReq = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] elig_i,
    output logic [NumReq-1:0] gnt_o
);

    localparam logic [1:0] LastRst = 2'(NumReq - 1);

    logic [MaxReq-1:0] elig_pad_s;
    logic [MaxReq-1:0] pick_s;
    logic [1:0]        last_s;
    logic              unused_pick_s;

    // Widen the eligibility vector to the helper's fixed width and pick the winner.
    always_comb begin
        elig_pad_s               = {MaxReq{1'b0}};
        elig_pad_s[NumReq-1:0]   = elig_i;
        pick_s                   = rr_pick(elig_pad_s, last_s, 3'(NumReq));
    end

    assign gnt_o         = pick_s[NumReq-1:0];
    assign unused_pick_s = ^pick_s;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [1:0] last_q;
    logic [1:0] last_d;

    // Pointer follows the winner of every grant and holds while idle.
    always_comb begin
        last_d = last_q;
        for (int k = 0; k < NumReq; k++) begin
            if (gnt_o[k]) begin
                last_d = 2'(k);
            end else begin
                last_d = last_d;
            end
        end
    end

    // Pointer register; reset value gives requester 0 first priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= LastRst;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_s = last_q;
`else
    logic unused_clk_rst_s;

    assign last_s           = LastRst;
    assign unused_clk_rst_s = clk_i ^ rst_ni;
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: combinational grant, SRAM drive muxing, read-return tracking.
// Build option: SRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NumReq    = 2,
    parameter int AddrWidth = SramAddrW,
    parameter int DataWidth = SramDataW
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            lock_i,
    input  logic [NumReq-1:0]               req_i,
    input  logic [NumReq-1:0]               we_i,
    input  logic [NumReq*AddrWidth-1:0]     addr_i,
    input  logic [NumReq*DataWidth-1:0]     wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   wmask_i,
    output logic [NumReq-1:0]               gnt_o,
    output logic [NumReq-1:0]               rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            csb_o,
    output logic                            web_o,
    output logic [AddrWidth-1:0]            addr_o,
    output logic [DataWidth-1:0]            wdata_o,
    output logic [DataWidth/8-1:0]          wmask_o,
    input  logic [DataWidth-1:0]            rdata_i
);

    localparam int MaskW = DataWidth / 8;

    logic [NumReq-1:0] elig_s;
    logic [NumReq-1:0] gnt_s;
    logic [NumReq-1:0] rd_owner_q;
    logic [NumReq-1:0] rd_owner_d;

    // Eligibility; masking with reset keeps every SRAM output idle while in reset.
    always_comb begin
        if (!rst_ni) begin
            elig_s = {NumReq{1'b0}};
        end else if (lock_i) begin
            elig_s = req_i & {{(NumReq-1){1'b0}}, 1'b1};
        end else begin
            elig_s = req_i;
        end
    end

    sram_arb_rr #(
        .NumReq (NumReq)
    ) u_pick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .elig_i (elig_s),
        .gnt_o  (gnt_s)
    );

    // AND-OR mux of the winner's payload; all-zero grant leaves the idle values.
    always_comb begin
        web_o   = 1'b1;
        addr_o  = {AddrWidth{1'b0}};
        wdata_o = {DataWidth{1'b0}};
        wmask_o = {MaskW{1'b0}};
        for (int k = 0; k < NumReq; k++) begin
            web_o   = web_o & ~(gnt_s[k] & we_i[k]);
            addr_o  = addr_o  | (addr_i[k*AddrWidth +: AddrWidth] & {AddrWidth{gnt_s[k]}});
            wdata_o = wdata_o | (wdata_i[k*DataWidth +: DataWidth] & {DataWidth{gnt_s[k]}});
            wmask_o = wmask_o | (wmask_i[k*MaskW +: MaskW] & {MaskW{gnt_s[k]}});
        end
    end

    assign gnt_o      = gnt_s;
    assign csb_o      = ~|gnt_s;
    assign rd_owner_d = gnt_s & ~we_i;

    // Remember who owns the read data arriving next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_owner_q <= {NumReq{1'b0}};
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign rvalid_o = rd_owner_q;
    assign rdata_o  = rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with an SRAM behavioural model and a reference model.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int NR = 2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              lock;
    logic [NR-1:0]     req, we;
    logic [NR*AW-1:0]  addr;
    logic [NR*DW-1:0]  wdata;
    logic [NR*MW-1:0]  wmask;
    logic [NR-1:0]     gnt, rvalid;
    logic [DW-1:0]     rdata, sram_rdata, wdata_o;
    logic              csb, web;
    logic [AW-1:0]     addr_o;
    logic [MW-1:0]     wmask_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] sram_mem [1024];
    logic [DW-1:0] ref_mem  [1024];

    always #5 clk = ~clk;

    sram_port_arbiter #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .lock_i(lock), .req_i(req), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .gnt_o(gnt),
        .rvalid_o(rvalid), .rdata_o(rdata), .csb_o(csb), .web_o(web),
        .addr_o(addr_o), .wdata_o(wdata_o), .wmask_o(wmask_o), .rdata_i(sram_rdata)
    );

    // SRAM macro: write commits at the edge, read data appears after the edge.
    always @(posedge clk) begin
        if (!csb) begin
            if (!web) begin
                for (int b = 0; b < MW; b++)
                    if (wmask_o[b]) sram_mem[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[addr_o];
            end
        end
    end

    // Reference model: winner index, expected outputs, pending read owner and data.
    int            m_last;
    logic [NR-1:0] m_rv;
    logic [DW-1:0] m_rdata;
    int            exp_win;
    logic [NR-1:0] m_elig, e_gnt;
    logic          e_csb, e_web;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [MW-1:0] e_wmask;

    always_comb begin
        exp_win = -1;
        m_elig  = lock ? (req & 2'b01) : req;
        if (rst_n === 1'b1) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            for (int s = 1; s <= NR; s++)
                if (exp_win < 0 && m_elig[(m_last + s) % NR]) exp_win = (m_last + s) % NR;
`else
            for (int i = 0; i < NR; i++)
                if (exp_win < 0 && m_elig[i]) exp_win = i;
`endif
        end
        e_gnt   = '0;
        e_csb   = 1'b1;
        e_web   = 1'b1;
        e_addr  = '0;
        e_wdata = '0;
        e_wmask = '0;
        if (exp_win >= 0) begin
            e_gnt[exp_win] = 1'b1;
            e_csb   = 1'b0;
            e_web   = ~we[exp_win];
            e_addr  = addr[exp_win*AW +: AW];
            e_wdata = wdata[exp_win*DW +: DW];
            e_wmask = wmask[exp_win*MW +: MW];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rv   <= '0;
            m_last <= NR - 1;
        end else begin
            m_rv <= '0;
            if (exp_win >= 0) begin
                m_last <= exp_win;
                if (we[exp_win]) begin
                    for (int b = 0; b < MW; b++)
                        if (wmask[exp_win*MW + b])
                            ref_mem[addr[exp_win*AW +: AW]][8*b +: 8] <= wdata[exp_win*DW + 8*b +: 8];
                end else begin
                    m_rv[exp_win] <= 1'b1;
                    m_rdata       <= ref_mem[addr[exp_win*AW +: AW]];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        chk("m_gnt", 64'(gnt), 64'(e_gnt));
        chk("m_csb", 64'(csb), 64'(e_csb));
        chk("m_web", 64'(web), 64'(e_web));
        chk("m_addr", 64'(addr_o), 64'(e_addr));
        chk("m_wdata", 64'(wdata_o), 64'(e_wdata));
        chk("m_wmask", 64'(wmask_o), 64'(e_wmask));
        chk("m_rvalid", 64'(rvalid), 64'(m_rv));
        if (m_rv != '0) chk("m_rdata", 64'(rdata), 64'(m_rdata));
    end

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic l,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [31:0] d0, input logic [3:0] m0);
        @(posedge clk);
        #1;
        req = r; we = w; lock = l;
        addr = {a1, a0}; wdata = {32'h0, d0}; wmask = {4'h0, m0};
        #1;
    endtask

    logic [1:0] cont_exp [4];

    initial begin
        rst_n = 1'b0; lock = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; wmask = '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        cont_exp[0] = 2'b01; cont_exp[1] = 2'b10; cont_exp[2] = 2'b01; cont_exp[3] = 2'b10;
`else
        cont_exp[0] = 2'b01; cont_exp[1] = 2'b01; cont_exp[2] = 2'b01; cont_exp[3] = 2'b01;
`endif
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = 32'(i) * 32'h0001_0001;
        end
        sram_mem[10'h010] = 32'hDEAD_BEEF;
        sram_mem[10'h3FF] = 32'hFFFF_FFFF;
        sram_mem[10'h001] = 32'hA5A5_0001;
        sram_mem[10'h002] = 32'h5A5A_0002;
        for (int i = 0; i < 1024; i++) ref_mem[i] = sram_mem[i];

        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_csb", 64'(csb), 64'h1);
        chk("rst_web", 64'(web), 64'h1);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        rst_n = 1'b1;

        // Single read by requester 1.
        drive(2'b10, 2'b00, 1'b0, 10'h000, 10'h010, 32'h0, 4'h0);
        chk("rd_gnt", 64'(gnt), 64'h2);
        chk("rd_csb", 64'(csb), 64'h0);
        chk("rd_web", 64'(web), 64'h1);
        chk("rd_addr", 64'(addr_o), 64'h010);
        drive(2'b00, 2'b00, 1'b0, 10'h000, 10'h000, 32'h0, 4'h0);
        chk("rd_rvalid", 64'(rvalid), 64'h2);
        chk("rd_rdata", 64'(rdata), 64'hDEAD_BEEF);

        // Contention between requesters 0 and 1.
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 2'b00, 1'b0, 10'h004, 10'h008, 32'h0, 4'h0);
            chk("contention", 64'(gnt), 64'(cont_exp[c]));
        end

        // Lock blocks requester 1 until dropped.
        for (int c = 0; c < 3; c++) begin
            drive(2'b10, 2'b00, 1'b1, 10'h000, 10'h020, 32'h0, 4'h0);
            chk("lock_gnt", 64'(gnt), 64'h0);
            chk("lock_csb", 64'(csb), 64'h1);
        end
        drive(2'b10, 2'b00, 1'b0, 10'h000, 10'h020, 32'h0, 4'h0);
        chk("unlock_gnt", 64'(gnt), 64'h2);

        // Masked write then read back.
        drive(2'b01, 2'b01, 1'b0, 10'h3FF, 10'h000, 32'h1234_5678, 4'b0011);
        chk("wr_gnt", 64'(gnt), 64'h1);
        chk("wr_web", 64'(web), 64'h0);
        chk("wr_wmask", 64'(wmask_o), 64'h3);
        drive(2'b01, 2'b00, 1'b0, 10'h3FF, 10'h000, 32'h0, 4'h0);
        chk("wr_no_rvalid", 64'(rvalid), 64'h0);
        drive(2'b00, 2'b00, 1'b0, 10'h000, 10'h000, 32'h0, 4'h0);
        chk("rb_rvalid", 64'(rvalid), 64'h1);
        chk("rb_rdata", 64'(rdata), 64'hFFFF_5678);

        // Back-to-back reads from different requesters.
        drive(2'b01, 2'b00, 1'b0, 10'h001, 10'h000, 32'h0, 4'h0);
        drive(2'b10, 2'b00, 1'b0, 10'h000, 10'h002, 32'h0, 4'h0);
        chk("b2b_gnt", 64'(gnt), 64'h2);
        chk("b2b_rvalid0", 64'(rvalid), 64'h1);
        chk("b2b_rdata0", 64'(rdata), 64'hA5A5_0001);
        drive(2'b00, 2'b00, 1'b0, 10'h000, 10'h000, 32'h0, 4'h0);
        chk("b2b_rvalid1", 64'(rvalid), 64'h2);
        chk("b2b_rdata1", 64'(rdata), 64'h5A5A_0002);

        // Reset in the cycle after a read grant drops the pending return.
        drive(2'b01, 2'b00, 1'b0, 10'h010, 10'h000, 32'h0, 4'h0);
        chk("rr_pre_gnt", 64'(gnt), 64'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", 64'(rvalid), 64'h0);
        chk("rst_mid_csb", 64'(csb), 64'h1);
        chk("rst_mid_gnt", 64'(gnt), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; req = '0;
        #1;
        chk("post_rst_rvalid", 64'(rvalid), 64'h0);
        drive(2'b11, 2'b00, 1'b0, 10'h005, 10'h006, 32'h0, 4'h0);
        chk("post_rst_gnt", 64'(gnt), 64'h1);
        chk("post_rst_rvalid2", 64'(rvalid), 64'h0);
        drive(2'b00, 2'b00, 1'b0, 10'h000, 10'h000, 32'h0, 4'h0);
        chk("post_rst_rv", 64'(rvalid), 64'h1);
        chk("post_rst_rdata", 64'(rdata), 64'h0005_0005);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
